scaled_result_display: RTL

- Downstream consumer of the 4-bit fixed-ratio scaler (operand F[3:0] in, scaled result Q[3:0] out).
- Captures the operand/result pair on a sample strobe and converts each to two decimal digits (0–15).
- Time-multiplexes the four digits onto the board's 4-digit active-low seven-segment display.
- Left pair shows the operand, right pair shows the result.

---
 rtl/display_pkg.sv | 21 ++
 rtl/seven_seg_decoder.sv | 26 ++
 rtl/scaled_result_display.sv | 89 ++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants and types for the scaled-result seven-segment display.
// Segment patterns are active-low, bit order gfedcba.
package display_pkg;

    typedef logic [3:0] digit_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational decimal digit to active-low seven-segment pattern.
// Anything outside 0-9 is shown blank.
module seven_seg_decoder
    import display_pkg::*;
(
    input  digit_t     digit,
    output logic [6:0] seg
);

    always_comb begin
        unique case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/scaled_result_display.sv
// Captures a scaler operand/result pair and scans it onto a 4-digit display:
// operand on the left pair, result on the right pair, decimal point between.
module scaled_result_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample,
    input  logic [3:0] operand,
    input  logic [3:0] result,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [3:0]       op_q;
    logic [3:0]       res_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic             wrap;

    logic [3:0]       value;
    logic             tens;
    logic [3:0]       ones;
    digit_t           digit;
    logic             blank;
    logic [6:0]       seg_dec;
    logic [3:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;

    assign wrap = (cnt == CNT_LAST);

    // Slots 3/2 carry the operand, 1/0 the result; odd slots are tens digits.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        value    = idx[1] ? op_q : res_q;
        tens     = (value >= 4'd10);
        ones     = tens ? (value - 4'd10) : value;
        digit    = idx[0] ? {3'b000, tens} : ones;
        blank    = idx[0] && !tens;
        an_next  = ~(4'b0001 << idx);
        seg_next = seg_dec;
        dp_next  = (idx != 2'd2);
        if (blank) begin
            an_next  = ANODE_OFF;
            seg_next = SEG_BLANK;
        end
    end

    seven_seg_decoder u_decoder (
        .digit (digit),
        .seg   (seg_dec)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            res_q      <= '0;
            cnt        <= '0;
            idx        <= '0;
            an         <= ANODE_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            if (sample) begin
                op_q  <= operand;
                res_q <= result;
            end
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                idx <= idx + 2'd1;
            end
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
            frame_done <= wrap && (idx == 2'd3);
        end
    end

endmodule
